// File: rtl/idu_pipe.sv
// idu_pipe: RV32I instruction queue feeding a single registered decode stage.
// Fetch pushes {pc, inst} into a DEPTH-entry circular queue; the head is
// decoded combinationally and captured into the output register whenever
// that register is empty or being consumed.
// Optional feature: define IDU_PIPE_HAZARD_EN to insert a one-cycle bubble
// between a LOAD and an immediately following consumer of its rd.
module idu_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     flush_i,
  input  logic                     inst_valid_i,
  output logic                     inst_ready_o,
  input  logic [XLEN-1:0]          inst_pc_i,
  input  logic [31:0]              inst_data_i,
  output logic                     dec_valid_o,
  input  logic                     dec_ready_i,
  output logic [XLEN-1:0]          dec_pc_o,
  output logic                     dec_rd_wr_en_o,
  output logic [4:0]               dec_rd_wr_addr_o,
  output logic [4:0]               dec_rs1_rd_addr_o,
  output logic [4:0]               dec_rs2_rd_addr_o,
  output logic                     dec_load_o,
  output logic [XLEN-1:0]          dec_imm_o,
  output logic [$clog2(DEPTH):0]   fifo_cnt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  logic [XLEN-1:0] r_pc_q   [DEPTH];
  logic [31:0]     r_inst_q [DEPTH];
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [CW-1:0]   r_cnt;

  logic            w_push, w_pop, w_load, w_stall, w_wr_en;
  logic [XLEN-1:0] w_head_pc, w_imm;
  logic [31:0]     w_head, w_imm32;
  logic [6:0]      w_opc;
  logic [4:0]      w_rd, w_rs1, w_rs2;

  // A full queue never accepts, even if the head leaves this same cycle.
  assign inst_ready_o = (r_cnt < DEPTH_C) && !flush_i;
  assign w_push       = inst_valid_i && inst_ready_o;
  assign w_load       = (r_cnt != '0) && !w_stall && (!dec_valid_o || dec_ready_i);
  assign w_pop        = w_load && !flush_i;
  assign fifo_cnt_o   = r_cnt;

  assign w_head_pc = r_pc_q[r_rptr];
  assign w_head    = r_inst_q[r_rptr];
  assign w_opc     = w_head[6:0];
  assign w_rd      = w_head[11:7];
  assign w_rs1     = w_head[19:15];
  assign w_rs2     = w_head[24:20];
  // Size cast of a signed 32-bit value sign-extends to XLEN.
  assign w_imm     = XLEN'($signed(w_imm32));

  // Head decode: rd write enable and 32-bit immediate by instruction format.
  always_comb begin
    w_wr_en = 1'b0;
    w_imm32 = '0;
    unique case (w_opc)
      OP_LUI, OP_AUIPC: begin
        w_wr_en = 1'b1;
        w_imm32 = {w_head[31:12], 12'b0};
      end
      OP_JAL: begin
        w_wr_en = 1'b1;
        w_imm32 = {{11{w_head[31]}}, w_head[31], w_head[19:12], w_head[20], w_head[30:21], 1'b0};
      end
      OP_JALR, OP_LOAD, OP_OPIMM: begin
        w_wr_en = 1'b1;
        w_imm32 = {{20{w_head[31]}}, w_head[31:20]};
      end
      OP_OP:     w_wr_en = 1'b1;
      OP_STORE:  w_imm32 = {{20{w_head[31]}}, w_head[31:25], w_head[11:7]};
      OP_BRANCH: w_imm32 = {{19{w_head[31]}}, w_head[31], w_head[7], w_head[30:25], w_head[11:8], 1'b0};
      default: ;
    endcase
    if (w_rd == 5'd0) w_wr_en = 1'b0;
  end

`ifdef IDU_PIPE_HAZARD_EN
  logic w_rs1_use, w_rs2_use;
  assign w_rs1_use = !(w_opc == OP_LUI || w_opc == OP_AUIPC || w_opc == OP_JAL);
  assign w_rs2_use = (w_opc == OP_STORE) || (w_opc == OP_BRANCH) || (w_opc == OP_OP);
  // Load-use: the load leaving now cannot forward to the head in time.
  assign w_stall = dec_valid_o && dec_ready_i && dec_load_o && dec_rd_wr_en_o &&
                   ((w_rs1_use && (w_rs1 == dec_rd_wr_addr_o)) ||
                    (w_rs2_use && (w_rs2 == dec_rd_wr_addr_o)));
`else
  assign w_stall = 1'b0;
`endif

  // Queue storage; contents are don't-care outside the occupied window.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_pc_q[r_wptr]   <= inst_pc_i;
      r_inst_q[r_wptr] <= inst_data_i;
    end
  end

  // Queue pointers and occupancy; flush wins over any push or pop.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else if (flush_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
    end
  end

  // Output stage: load a new head, drain when consumed, otherwise hold.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dec_valid_o       <= 1'b0;
      dec_pc_o          <= '0;
      dec_rd_wr_en_o    <= 1'b0;
      dec_rd_wr_addr_o  <= '0;
      dec_rs1_rd_addr_o <= '0;
      dec_rs2_rd_addr_o <= '0;
      dec_load_o        <= 1'b0;
      dec_imm_o         <= '0;
    end else if (flush_i) begin
      dec_valid_o <= 1'b0;
    end else if (w_load) begin
      dec_valid_o       <= 1'b1;
      dec_pc_o          <= w_head_pc;
      dec_rd_wr_en_o    <= w_wr_en;
      dec_rd_wr_addr_o  <= w_rd;
      dec_rs1_rd_addr_o <= w_rs1;
      dec_rs2_rd_addr_o <= w_rs2;
      dec_load_o        <= (w_opc == OP_LOAD);
      dec_imm_o         <= w_imm;
    end else if (dec_ready_i) begin
      dec_valid_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_idu_pipe.sv
// Directed bench for idu_pipe (XLEN=32, DEPTH=4). Inputs change and outputs
// are sampled 1ns after each rising edge.
module tb_idu_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        inst_valid = 1'b0;
  logic        inst_ready;
  logic [31:0] inst_pc = '0;
  logic [31:0] inst_data = '0;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] dec_pc;
  logic        dec_wr_en;
  logic [4:0]  dec_rd, dec_rs1, dec_rs2;
  logic        dec_load;
  logic [31:0] dec_imm;
  logic [2:0]  fifo_cnt;

  int n_chk = 0;
  int n_fail = 0;

  idu_pipe #(.XLEN(32), .DEPTH(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .inst_valid_i(inst_valid), .inst_ready_o(inst_ready),
    .inst_pc_i(inst_pc), .inst_data_i(inst_data),
    .dec_valid_o(dec_valid), .dec_ready_i(dec_ready), .dec_pc_o(dec_pc),
    .dec_rd_wr_en_o(dec_wr_en), .dec_rd_wr_addr_o(dec_rd),
    .dec_rs1_rd_addr_o(dec_rs1), .dec_rs2_rd_addr_o(dec_rs2),
    .dec_load_o(dec_load), .dec_imm_o(dec_imm), .fifo_cnt_o(fifo_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] addi_w(input int n);
    return (32'(n) << 20) | (32'(n) << 7) | 32'h13;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_chk++; if (fifo_cnt !== 3'd0) begin $display("FAIL rst_cnt got %0d exp 0", fifo_cnt); n_fail++; end
    n_chk++; if (dec_valid !== 1'b0) begin $display("FAIL rst_valid got %b exp 0", dec_valid); n_fail++; end
    n_chk++; if ({dec_wr_en, dec_load, dec_rd, dec_rs1, dec_rs2} !== 17'd0) begin
      $display("FAIL rst_ctl got %h exp 0", {dec_wr_en, dec_load, dec_rd, dec_rs1, dec_rs2}); n_fail++; end
    n_chk++; if ({dec_pc, dec_imm} !== 64'd0) begin $display("FAIL rst_pcimm got %h exp 0", {dec_pc, dec_imm}); n_fail++; end
    tick();
    rst_n = 1'b1;
    tick();
    n_chk++; if (inst_ready !== 1'b1) begin $display("FAIL rst_ready got %b exp 1", inst_ready); n_fail++; end
  endtask

  task automatic test_basic();
    dec_ready = 1'b1;
    inst_valid = 1'b1; inst_pc = 32'h100; inst_data = 32'h00500093;
    tick();
    inst_valid = 1'b0;
    n_chk++; if (dec_valid !== 1'b0 || fifo_cnt !== 3'd1) begin
      $display("FAIL basic_lat1 got valid=%b cnt=%0d exp valid=0 cnt=1", dec_valid, fifo_cnt); n_fail++; end
    tick();
    n_chk++; if (dec_valid !== 1'b1) begin $display("FAIL basic_valid got %b exp 1", dec_valid); n_fail++; end
    n_chk++; if (dec_rd !== 5'd1 || dec_wr_en !== 1'b1 || dec_load !== 1'b0) begin
      $display("FAIL basic_rd got rd=%0d en=%b ld=%b exp rd=1 en=1 ld=0", dec_rd, dec_wr_en, dec_load); n_fail++; end
    n_chk++; if (dec_imm !== 32'd5 || dec_pc !== 32'h100) begin
      $display("FAIL basic_imm got imm=%h pc=%h exp imm=5 pc=100", dec_imm, dec_pc); n_fail++; end
    n_chk++; if (fifo_cnt !== 3'd0) begin $display("FAIL basic_cnt got %0d exp 0", fifo_cnt); n_fail++; end
    tick();
    n_chk++; if (dec_valid !== 1'b0) begin $display("FAIL basic_drain got %b exp 0", dec_valid); n_fail++; end
  endtask

  task automatic test_full();
    dec_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      inst_valid = 1'b1; inst_pc = 32'h200 + 32'(4 * i); inst_data = addi_w(i + 1);
      n_chk++; if (inst_ready !== 1'b1) begin $display("FAIL full_acc%0d got %b exp 1", i, inst_ready); n_fail++; end
      tick();
    end
    n_chk++; if (fifo_cnt !== 3'd4 || inst_ready !== 1'b0) begin
      $display("FAIL full_cnt got cnt=%0d rdy=%b exp cnt=4 rdy=0", fifo_cnt, inst_ready); n_fail++; end
    inst_pc = 32'h300; inst_data = addi_w(9);
    tick(); tick();
    n_chk++; if (fifo_cnt !== 3'd4 || dec_valid !== 1'b1 || dec_pc !== 32'h200 || dec_imm !== 32'd1) begin
      $display("FAIL full_hold got cnt=%0d v=%b pc=%h imm=%h exp 4 1 200 1", fifo_cnt, dec_valid, dec_pc, dec_imm); n_fail++; end
    dec_ready = 1'b1;
    #1;
    n_chk++; if (inst_ready !== 1'b0) begin $display("FAIL full_nopass got %b exp 0", inst_ready); n_fail++; end
    inst_valid = 1'b0;
    for (int j = 1; j < 5; j++) begin
      tick();
      n_chk++; if (dec_valid !== 1'b1 || dec_pc !== 32'h200 + 32'(4 * j) || dec_imm !== 32'(j + 1) || dec_rd !== 5'(j + 1)) begin
        $display("FAIL full_order%0d got v=%b pc=%h imm=%h rd=%0d exp pc=%h imm=%0d", j, dec_valid, dec_pc, dec_imm, dec_rd,
                 32'h200 + 32'(4 * j), j + 1); n_fail++; end
    end
    tick();
    n_chk++; if (dec_valid !== 1'b0 || fifo_cnt !== 3'd0) begin
      $display("FAIL full_empty got v=%b cnt=%0d exp 0 0", dec_valid, fifo_cnt); n_fail++; end
  endtask

  task automatic test_hazard();
    dec_ready = 1'b1;
    inst_valid = 1'b1; inst_pc = 32'h400; inst_data = 32'h00012283;  // lw x5,0(x2)
    tick();
    inst_pc = 32'h404; inst_data = 32'h00128333;                      // add x6,x5,x1
    tick();
    inst_valid = 1'b0;
    n_chk++; if (dec_valid !== 1'b1 || dec_load !== 1'b1 || dec_rd !== 5'd5 || dec_rs1 !== 5'd2) begin
      $display("FAIL hz_lw got v=%b ld=%b rd=%0d rs1=%0d exp 1 1 5 2", dec_valid, dec_load, dec_rd, dec_rs1); n_fail++; end
    tick();
`ifdef IDU_PIPE_HAZARD_EN
    n_chk++; if (dec_valid !== 1'b0 || fifo_cnt !== 3'd1) begin
      $display("FAIL hz_bubble got v=%b cnt=%0d exp 0 1", dec_valid, fifo_cnt); n_fail++; end
    tick();
`endif
    n_chk++; if (dec_valid !== 1'b1 || dec_pc !== 32'h404 || dec_rd !== 5'd6 || dec_rs1 !== 5'd5 ||
                 dec_rs2 !== 5'd1 || dec_wr_en !== 1'b1 || dec_load !== 1'b0 || dec_imm !== 32'd0) begin
      $display("FAIL hz_add got v=%b pc=%h rd=%0d rs1=%0d rs2=%0d en=%b ld=%b imm=%h exp 1 404 6 5 1 1 0 0",
               dec_valid, dec_pc, dec_rd, dec_rs1, dec_rs2, dec_wr_en, dec_load, dec_imm); n_fail++; end
    tick();
  endtask

  task automatic test_flush();
    dec_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      inst_valid = 1'b1; inst_pc = 32'h500 + 32'(4 * i); inst_data = addi_w(i + 1);
      tick();
    end
    n_chk++; if (fifo_cnt !== 3'd3 || dec_valid !== 1'b1) begin
      $display("FAIL fl_pre got cnt=%0d v=%b exp 3 1", fifo_cnt, dec_valid); n_fail++; end
    flush = 1'b1; inst_pc = 32'h5F0; inst_data = addi_w(7);
    #1;
    n_chk++; if (inst_ready !== 1'b0) begin $display("FAIL fl_ready got %b exp 0", inst_ready); n_fail++; end
    tick();
    flush = 1'b0; inst_valid = 1'b0;
    n_chk++; if (fifo_cnt !== 3'd0 || dec_valid !== 1'b0) begin
      $display("FAIL fl_clear got cnt=%0d v=%b exp 0 0", fifo_cnt, dec_valid); n_fail++; end
    tick();
    n_chk++; if (fifo_cnt !== 3'd0 || dec_valid !== 1'b0) begin
      $display("FAIL fl_drop got cnt=%0d v=%b exp 0 0", fifo_cnt, dec_valid); n_fail++; end
    dec_ready = 1'b1;
    inst_valid = 1'b1; inst_pc = 32'h600; inst_data = addi_w(3);
    tick();
    inst_valid = 1'b0;
    tick();
    n_chk++; if (dec_valid !== 1'b1 || dec_pc !== 32'h600 || dec_imm !== 32'd3) begin
      $display("FAIL fl_after got v=%b pc=%h imm=%h exp 1 600 3", dec_valid, dec_pc, dec_imm); n_fail++; end
    tick();
  endtask

  task automatic test_imm();
    logic [31:0] words [8];
    logic [31:0] imms  [8];
    logic [7:0]  en    = 8'b0011_0100;  // bit k: expected wr_en of vector k
    logic [7:0]  ld    = 8'b0010_0000;
    words = '{32'hFE208EE3, 32'hFE20AC23, 32'hFF9FF0EF, 32'h00100013,
              32'h800001B7, 32'hFFC12283, 32'h00128333, 32'hFFFFFFFF};
    imms  = '{32'hFFFFFFFC, 32'hFFFFFFF8, 32'hFFFFFFF8, 32'h00000001,
              32'h80000000, 32'hFFFFFFFC, 32'h00000000, 32'h00000000};
    en[4] = 1'b1; en[6] = 1'b1;
    dec_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      inst_valid = 1'b1; inst_pc = 32'h700 + 32'(4 * k); inst_data = words[k];
      tick();
      inst_valid = 1'b0;
      tick();
      n_chk++; if (dec_valid !== 1'b1 || dec_imm !== imms[k] || dec_wr_en !== en[k] || dec_load !== ld[k]) begin
        $display("FAIL imm%0d got v=%b imm=%h en=%b ld=%b exp 1 %h %b %b", k, dec_valid, dec_imm, dec_wr_en, dec_load,
                 imms[k], en[k], ld[k]); n_fail++; end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    dec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      inst_valid = 1'b1; inst_pc = 32'h800 + 32'(4 * i); inst_data = addi_w(i + 1);
      tick();
    end
    inst_valid = 1'b0;
    n_chk++; if (fifo_cnt !== 3'd2 || dec_valid !== 1'b1) begin
      $display("FAIL rm_pre got cnt=%0d v=%b exp 2 1", fifo_cnt, dec_valid); n_fail++; end
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++; if (fifo_cnt !== 3'd0 || dec_valid !== 1'b0 || dec_wr_en !== 1'b0 || dec_load !== 1'b0) begin
      $display("FAIL rm_async got cnt=%0d v=%b en=%b ld=%b exp 0", fifo_cnt, dec_valid, dec_wr_en, dec_load); n_fail++; end
    n_chk++; if ({dec_pc, dec_imm} !== 64'd0 || {dec_rd, dec_rs1, dec_rs2} !== 15'd0) begin
      $display("FAIL rm_zero got %h %h exp 0", {dec_pc, dec_imm}, {dec_rd, dec_rs1, dec_rs2}); n_fail++; end
    #4;
    rst_n = 1'b1;
    dec_ready = 1'b1;
    tick(); tick(); tick();
    n_chk++; if (fifo_cnt !== 3'd0 || dec_valid !== 1'b0 || inst_ready !== 1'b1) begin
      $display("FAIL rm_after got cnt=%0d v=%b rdy=%b exp 0 0 1", fifo_cnt, dec_valid, inst_ready); n_fail++; end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_hazard();
    test_flush();
    test_imm();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/idu_pipe.md
IDU_PIPE -- requirements
Module: idu_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width of PC and immediate (32 or 64).
REQ-002 SHALL have parameter DEPTH, default 4, instruction-queue entries (power of two, >=2).
REQ-003 SHALL have port clk_i  input  1  clock, all state on rising edge.
REQ-004 SHALL have port rst_n_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush_i  input  1  discard all queued and output-stage instructions.
REQ-006 SHALL have port inst_valid_i  input  1  fetch offers an instruction.
REQ-007 SHALL have port inst_ready_o  output  1  queue can accept an instruction.
REQ-008 SHALL have port inst_pc_i  input  XLEN  PC of offered instruction.
REQ-009 SHALL have port inst_data_i  input  32  offered RV32I instruction word.
REQ-010 SHALL have port dec_valid_o  output  1  decoded bundle valid.
REQ-011 SHALL have port dec_ready_i  input  1  execute stage consumes the bundle.
REQ-012 SHALL have port dec_pc_o  output  XLEN  PC of decoded instruction.
REQ-013 SHALL have port dec_rd_wr_en_o  output  1  instruction writes rd.
REQ-014 SHALL have port dec_rd_wr_addr_o  output  5  rd field.
REQ-015 SHALL have port dec_rs1_rd_addr_o  output  5  rs1 field.
REQ-016 SHALL have port dec_rs2_rd_addr_o  output  5  rs2 field.
REQ-017 SHALL have port dec_load_o  output  1  instruction is LOAD (opcode 0000011).
REQ-018 SHALL have port dec_imm_o  output  XLEN  sign-extended immediate.
REQ-019 SHALL have port fifo_cnt_o  output  $clog2(DEPTH)+1  queue occupancy.

Function
REQ-020 SHALL push {inst_pc_i, inst_data_i} when inst_valid_i && inst_ready_o; inst_ready_o = (fifo_cnt_o < DEPTH) && !flush_i; no pass-through when full, even with a simultaneous pop.
REQ-021 SHALL wrap read/write pointers modulo DEPTH; occupancy is +1 on push only, -1 on pop only, unchanged on both.
REQ-022 SHALL load the output register from the queue head when the queue is non-empty, no stall is active, and (!dec_valid_o || dec_ready_i).
REQ-023 SHALL present an instruction accepted at edge k on dec_valid_o after edge k+1 (latency 2 from empty).
REQ-024 SHALL hold all dec_* outputs stable while dec_valid_o && !dec_ready_i.
REQ-025 SHALL clear dec_valid_o after an edge where dec_ready_i is high and no new head is loaded.
REQ-026 SHALL assert dec_rd_wr_en_o for opcodes LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP only when rd != 0.
REQ-027 SHALL form dec_imm_o from the I/S/B/U/J format selected by opcode, sign-extended from bit 31 to XLEN, and 0 for OP and unknown opcodes.
REQ-028 SHALL treat rs1 as used by all opcodes except LUI/AUIPC/JAL, and rs2 as used by STORE/BRANCH/OP.
REQ-029 SHALL, on flush_i, empty the queue, zero the pointers and clear dec_valid_o at the next edge; flush_i has priority over a simultaneous push, pop or stall.

Reset
REQ-030 SHALL, while rst_n_i is low, force pointers, fifo_cnt_o, dec_valid_o, dec_rd_wr_en_o and dec_load_o to 0, all other dec_* outputs to 0, and inst_ready_o to 1 once released.
REQ-031 SHALL abandon queued instructions on a mid-operation reset; none reappear afterwards.

Configuration
REQ-032 SHALL, with IDU_PIPE_HAZARD_EN defined, stall one cycle when the output register holds a LOAD with rd != 0 being consumed and the head uses that register as rs1/rs2 (per REQ-028): dec_valid_o low one cycle, head not popped.
REQ-033 SHALL, without IDU_PIPE_HAZARD_EN, never stall, and contain no hazard logic.

Verification
REQ-034 SHALL cover: push 0x00500093 (addi x1,x0,5) at PC 0x100 into empty queue -> two edges later dec_valid_o=1, rd=1, wr_en=1, imm=5.
REQ-035 SHALL cover: push 5 words with dec_ready_i=0, DEPTH=4 -> inst_ready_o=0 at fifo_cnt_o=4, output stable, order preserved on release.
REQ-036 SHALL cover: lw x5,0(x2) then add x6,x5,x1 with hazard enabled -> one bubble cycle; disabled -> back-to-back.
REQ-037 SHALL cover: flush_i with 3 queued and inst_valid_i=1 -> next cycle fifo_cnt_o=0, dec_valid_o=0, pushed word dropped.
REQ-038 SHALL cover: sw/beq/jal with negative offsets (e.g. beq imm -4) -> dec_imm_o = 0xFFFFFFFC; addi x0,... -> dec_rd_wr_en_o=0.
REQ-039 SHALL cover: rst_n_i low mid-stream with 2 queued -> all outputs zero asynchronously, queue empty after release.
